// File: rtl/cmd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the SUMP command decoder: opcode values, arm-FSM
// state encoding and the trigger-write kind produced by cmd_trig_dec.
// ---------------------------------------------------------------------------
package cmd_pkg;

  // SUMP opcodes
  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;
  localparam logic [7:0] OP_TRIG_MASK = 8'hC0;  // base; stage in op[3:2]
  localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;  // base; stage in op[3:2]
  localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;  // base; stage in op[3:2]
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TRIG_NONE = 2'd0,
    TRIG_MASK = 2'd1,
    TRIG_VAL  = 2'd2,
    TRIG_CFG  = 2'd3
  } trig_kind_e;

endpackage

// File: rtl/cmd_trig_dec.sv
// ---------------------------------------------------------------------------
// cmd_trig_dec
// Pure combinational decode of the trigger opcode range C0..CF.
//   opcode_i  in   8  command opcode
//   kind_o    out  2  TRIG_MASK / TRIG_VAL / TRIG_CFG, or TRIG_NONE when the
//                     opcode is not a trigger write (incl. C3/C7/CB/CF)
//   stage_o   out  2  trigger stage index, op[3:2]
// ---------------------------------------------------------------------------
module cmd_trig_dec
  import cmd_pkg::*;
(
  input  logic [7:0] opcode_i,
  output trig_kind_e kind_o,
  output logic [1:0] stage_o
);

  logic [7:0] op_base;

  // Strip the stage field so each stage maps onto the same base opcode.
  assign op_base = {opcode_i[7:4], 2'b00, opcode_i[1:0]};
  assign stage_o = opcode_i[3:2];

  // NOTE: kind_o gets a default before the if-chain so no path leaves it
  // unassigned; without it this block would infer a latch.
  always_comb begin
    kind_o = TRIG_NONE;
    if (op_base == OP_TRIG_MASK)     kind_o = TRIG_MASK;
    else if (op_base == OP_TRIG_VAL) kind_o = TRIG_VAL;
    else if (op_base == OP_TRIG_CFG) kind_o = TRIG_CFG;
  end

endmodule

// File: rtl/cmd_decoder.sv
// ---------------------------------------------------------------------------
// cmd_decoder
// Consumes {data,opcode}+execute from the UART command interface and turns
// each SUMP command into one-cycle trigger write strobes and held capture
// configuration registers. Owns the arm FSM; config is locked while armed.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd[39:0]           {data[31:0], opcode[7:0]}, valid while execute high
//   execute             command valid (level; rising edge = one command)
//   capture_done        one-cycle pulse from the core, capture finished
//   core_reset          one-cycle soft reset pulse for sampler/trigger core
//   armed               capture armed, config locked
//   trig_wr_mask/val/cfg one-cycle strobes, qualify trig_stage/trig_data
//   divider, read_count, delay_count, flags   held configuration
//   err_count           rejected-command counter
//
// Build option: define CMD_ERRCNT_EN to get a saturating rejected-command
// counter on err_count; otherwise err_count is tied to 0.
// ---------------------------------------------------------------------------
module cmd_decoder
  import cmd_pkg::*;
#(
  parameter int RESET_COUNT = 1,   // consecutive 0x00 commands per core_reset (1..7)
  parameter int DIV_W       = 24   // divider width (<= 32)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [39:0]      cmd,
  input  logic             execute,
  input  logic             capture_done,
  output logic             core_reset,
  output logic             armed,
  output logic             trig_wr_mask,
  output logic             trig_wr_val,
  output logic             trig_wr_cfg,
  output logic [1:0]       trig_stage,
  output logic [31:0]      trig_data,
  output logic [DIV_W-1:0] divider,
  output logic [15:0]      read_count,
  output logic [15:0]      delay_count,
  output logic [15:0]      flags,
  output logic [7:0]       err_count
);

  localparam logic [2:0] RC_LAST = 3'(RESET_COUNT - 1);

  logic [7:0]  opcode;
  logic [31:0] data;
  assign opcode = cmd[7:0];
  assign data   = cmd[39:8];

  logic       exec_q;
  logic       accept;
  state_e     state_q, state_d, state_eff;
  logic [2:0] rst_cnt_q, rst_cnt_d;
  logic       core_reset_d;
  trig_kind_e trig_kind;
  logic [1:0] trig_stage_dec;
  logic       op_cfg, locked, cfg_wr;

  cmd_trig_dec u_trig_dec (
    .opcode_i (opcode),
    .kind_o   (trig_kind),
    .stage_o  (trig_stage_dec)
  );

  assign accept = execute & ~exec_q;

  // capture_done is applied before the command of the same cycle, so the
  // lock check and the arm decision both see the post-capture state.
  assign state_eff = capture_done ? ST_IDLE : state_q;
  assign locked    = (state_eff == ST_ARMED);

  assign op_cfg = (trig_kind != TRIG_NONE) || (opcode == OP_DIV) ||
                  (opcode == OP_CNT) || (opcode == OP_FLAGS);
  assign cfg_wr = accept && op_cfg && !locked;

  assign core_reset_d = accept && (opcode == OP_RESET) && (rst_cnt_q == RC_LAST);

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (accept) begin
      if (opcode == OP_RESET) rst_cnt_d = core_reset_d ? 3'd0 : rst_cnt_q + 3'd1;
      else                    rst_cnt_d = 3'd0;
    end

    state_d = state_eff;
    if (core_reset_d)                        state_d = ST_IDLE;
    else if (accept && (opcode == OP_ARM))   state_d = ST_ARMED;
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Resetting to 1 means an execute still high after reset release is
      // not mistaken for a fresh rising edge.
      exec_q       <= 1'b1;
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      core_reset   <= 1'b0;
      trig_wr_mask <= 1'b0;
      trig_wr_val  <= 1'b0;
      trig_wr_cfg  <= 1'b0;
      trig_stage   <= '0;
      trig_data    <= '0;
      divider      <= '0;
      read_count   <= '0;
      delay_count  <= '0;
      flags        <= '0;
    end else begin
      exec_q       <= execute;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset   <= core_reset_d;
      trig_wr_mask <= cfg_wr && (trig_kind == TRIG_MASK);
      trig_wr_val  <= cfg_wr && (trig_kind == TRIG_VAL);
      trig_wr_cfg  <= cfg_wr && (trig_kind == TRIG_CFG);
      if (cfg_wr && (trig_kind != TRIG_NONE)) begin
        trig_stage <= trig_stage_dec;
        trig_data  <= data;
      end
      if (cfg_wr && (opcode == OP_DIV)) divider <= data[DIV_W-1:0];
      if (cfg_wr && (opcode == OP_CNT)) begin
        read_count  <= data[15:0];
        delay_count <= data[31:16];
      end
      if (cfg_wr && (opcode == OP_FLAGS)) flags <= data[15:0];
    end
  end

  assign armed = (state_q == ST_ARMED);

`ifdef CMD_ERRCNT_EN
  logic       op_known;
  logic       reject;
  logic [7:0] err_q;

  // Housekeeping opcodes are handled upstream and are silently accepted.
  assign op_known = op_cfg || (opcode == OP_RESET) || (opcode == OP_ARM) ||
                    (opcode == OP_ID) || (opcode == OP_META) ||
                    (opcode == OP_XON) || (opcode == OP_XOFF);
  assign reject   = accept && (!op_known || (op_cfg && locked));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            err_q <= '0;
    else if (core_reset_d)               err_q <= '0;
    else if (reject && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_cmd_decoder
// Directed bench for cmd_decoder (RESET_COUNT=5, DIV_W=24). Expected
// err_count follows CMD_ERRCNT_EN: counted rejections when defined, 0 if not.
// ---------------------------------------------------------------------------
module tb_cmd_decoder;

  localparam int DIV_W = 24;
`ifdef CMD_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [39:0]      cmd = '0;
  logic             execute = 1'b0;
  logic             capture_done = 1'b0;
  logic             core_reset, armed;
  logic             trig_wr_mask, trig_wr_val, trig_wr_cfg;
  logic [1:0]       trig_stage;
  logic [31:0]      trig_data;
  logic [DIV_W-1:0] divider;
  logic [15:0]      read_count, delay_count, flags;
  logic [7:0]       err_count;
  logic [2:0]       stb;

  cmd_decoder #(.RESET_COUNT(5), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .execute      (execute),
    .capture_done (capture_done),
    .core_reset   (core_reset),
    .armed        (armed),
    .trig_wr_mask (trig_wr_mask),
    .trig_wr_val  (trig_wr_val),
    .trig_wr_cfg  (trig_wr_cfg),
    .trig_stage   (trig_stage),
    .trig_data    (trig_data),
    .divider      (divider),
    .read_count   (read_count),
    .delay_count  (delay_count),
    .flags        (flags),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  assign stb = {trig_wr_mask, trig_wr_val, trig_wr_cfg};

  int tests   = 0;
  int fails   = 0;
  int exp_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] err_exp();
    return ERR_EN ? 32'(exp_err) : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One low cycle, then a single-cycle execute; outputs of the accept edge
  // are visible on return.
  task automatic send(input logic [7:0] op, input logic [31:0] d);
    step();
    cmd     = {d, op};
    execute = 1'b1;
    step();
    execute = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_divider", 32'(divider), 32'h0);
    check("rst_armed", 32'(armed), 32'h0);
    check("rst_core_reset", 32'(core_reset), 32'h0);
    check("rst_strobes", 32'(stb), 32'h0);
    check("rst_trig_data", trig_data, 32'h0);
    check("rst_counts", {read_count, delay_count}, 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    rst = 1'b1;
    step();

    // 1: held execute writes divider once
    step();
    cmd     = {32'h0000_1234, 8'h80};
    execute = 1'b1;
    step();
    check("div_latency1", 32'(divider), 32'h0000_1234);
    cmd = {32'h0000_5678, 8'h80};
    repeat (4) step();
    check("div_held_once", 32'(divider), 32'h0000_1234);
    check("div_err", 32'(err_count), err_exp());
    execute = 1'b0;

    // 2: trigger writes
    send(8'hC6, 32'hDEAD_BEEF);
    check("c6_strobes", 32'(stb), 32'b001);
    check("c6_stage", 32'(trig_stage), 32'd1);
    check("c6_data", trig_data, 32'hDEAD_BEEF);
    step();
    check("c6_strobe_1cyc", 32'(stb), 32'b000);
    send(8'hC0, 32'h1111_1111);
    check("c0_strobes", 32'(stb), 32'b100);
    check("c0_stage", 32'(trig_stage), 32'd0);
    send(8'hC9, 32'h0000_0022);
    check("c9_strobes", 32'(stb), 32'b010);
    check("c9_stage", 32'(trig_stage), 32'd2);
    send(8'hC3, 32'h0000_0033);
    exp_err++;
    check("c3_strobes", 32'(stb), 32'b000);
    check("c3_data_kept", trig_data, 32'h0000_0022);
    check("c3_err", 32'(err_count), err_exp());

    // 3: counts, arm, lock
    send(8'h81, 32'h0040_0100);
    check("read_count", 32'(read_count), 32'h0100);
    check("delay_count", 32'(delay_count), 32'h0040);
    send(8'h02, 32'h0);
    check("ignored_02_err", 32'(err_count), err_exp());
    send(8'h01, 32'h0);
    check("arm", 32'(armed), 32'h1);
    send(8'h82, 32'h0000_0003);
    exp_err++;
    check("locked_flags", 32'(flags), 32'h0);
    check("locked_flags_err", 32'(err_count), err_exp());
    send(8'h80, 32'h00FF_FFFF);
    exp_err++;
    check("locked_div", 32'(divider), 32'h0000_1234);
    send(8'hC0, 32'h0);
    exp_err++;
    check("locked_trig_stb", 32'(stb), 32'b000);
    send(8'h01, 32'h0);
    check("rearm_armed", 32'(armed), 32'h1);
    check("rearm_no_err", 32'(err_count), err_exp());

    // 5: capture_done interactions
    step();
    cmd          = {32'h0, 8'h01};
    execute      = 1'b1;
    capture_done = 1'b1;
    step();
    execute      = 1'b0;
    capture_done = 1'b0;
    check("cd_plus_arm", 32'(armed), 32'h1);
    step();
    capture_done = 1'b1;
    step();
    capture_done = 1'b0;
    check("cd_alone", 32'(armed), 32'h0);
    send(8'h01, 32'h0);
    step();
    cmd          = {32'h00AB_CDEF, 8'h80};
    execute      = 1'b1;
    capture_done = 1'b1;
    step();
    execute      = 1'b0;
    capture_done = 1'b0;
    check("cd_plus_div", 32'(divider), 32'h00AB_CDEF);
    check("cd_plus_div_armed", 32'(armed), 32'h0);
    check("cd_plus_div_err", 32'(err_count), err_exp());

    // 4: RESET_COUNT=5 with an interrupting arm
    for (int i = 0; i < 4; i++) begin
      send(8'h00, 32'h0);
      check("rc_pre_arm", 32'(core_reset), 32'h0);
    end
    send(8'h01, 32'h0);
    check("rc_arm", 32'(armed), 32'h1);
    for (int i = 0; i < 5; i++) begin
      send(8'h00, 32'h0);
      if (i < 4) begin
        check("rc_no_pulse", 32'(core_reset), 32'h0);
        check("rc_still_armed", 32'(armed), 32'h1);
      end
    end
    exp_err = 0;
    check("rc_pulse", 32'(core_reset), 32'h1);
    check("rc_disarm", 32'(armed), 32'h0);
    check("rc_div_kept", 32'(divider), 32'h00AB_CDEF);
    check("rc_count_kept", 32'(read_count), 32'h0100);
    check("rc_err_clear", 32'(err_count), err_exp());
    step();
    check("rc_pulse_1cyc", 32'(core_reset), 32'h0);

    // 6: unknown opcode, then async reset mid-execute
    send(8'h55, 32'h0);
    exp_err++;
    check("op55_strobes", 32'(stb), 32'b000);
    check("op55_err", 32'(err_count), err_exp());
    step();
    cmd     = {32'h0000_0777, 8'h80};
    execute = 1'b1;
    step();
    check("pre_rst_div", 32'(divider), 32'h0000_0777);
    cmd = {32'h0000_0888, 8'h80};
    #2 rst = 1'b0;
    #1;
    check("async_rst_div", 32'(divider), 32'h0);
    check("async_rst_data", trig_data, 32'h0);
    check("async_rst_counts", {read_count, delay_count}, 32'h0);
    check("async_rst_err", 32'(err_count), 32'h0);
    step();
    rst = 1'b1;
    repeat (3) step();
    check("held_exec_ignored", 32'(divider), 32'h0);
    execute = 1'b0;
    step();
    execute = 1'b1;
    step();
    check("rerise_accepted", 32'(divider), 32'h0000_0888);
    execute = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
